// File: rtl/powlib_dpram_rdr_if.sv
// Bus bundle for powlib_dpram_rdr: command/status, dpram read port and the
// outgoing valid/ready word stream. The master modport is the reader engine;
// the slave modport is the surrounding system (command source, RAM, sink).
interface powlib_dpram_rdr_if #(
   parameter int W    = 16,
   parameter int D    = 8,
   parameter int WIDX = $clog2(D),
   parameter int WLEN = WIDX + 1
);
   // command and status
   logic            start;
   logic [WIDX-1:0] base;
   logic [WLEN-1:0] len;
   logic            busy;
   logic            done;
   // dpram read port (combinational read)
   logic [WIDX-1:0] rdidx;
   logic [W-1:0]    rddata;
   // output word stream
   logic [W-1:0]    outdata;
   logic            outvld;
   logic            outrdy;

   modport master (
      input  start, base, len, rddata, outrdy,
      output busy, done, rdidx, outdata, outvld
   );

   modport slave (
      output start, base, len, rddata, outrdy,
      input  busy, done, rdidx, outdata, outvld
   );
endinterface

// File: rtl/powlib_dpram_rdr.sv
// Read-side engine for powlib_dpram. On start it walks a wrap-around range of
// indices, presents each index to the RAM's combinational read port and
// streams the returned word through a single registered valid/ready stage.
// A one-cycle done pulse marks the end of each command.
module powlib_dpram_rdr #(
   parameter int W    = 16,
   parameter int D    = 8,
   parameter int WIDX = $clog2(D),
   parameter int WLEN = WIDX + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   powlib_dpram_rdr_if.master      bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [WIDX-1:0] IDX_LAST = WIDX'(D - 1);

   state_t          state;
   state_t          state_nxt;
   logic [WIDX-1:0] idx;
   logic [WLEN-1:0] rem;
   logic [W-1:0]    outdata;
   logic            outvld;

   logic            xfer;
   logic            out_free;
   logic            issue;
   logic            accept;

   // Output register can take a new word when empty or emptying this cycle;
   // outrdy only feeds register enables, never an output directly.
   assign xfer     = outvld & bus.outrdy;
   assign out_free = ~outvld | bus.outrdy;
   assign issue    = (state == READ) && (rem != '0) && out_free;
   assign accept   = (state == IDLE) && bus.start;

   assign bus.busy    = (state != IDLE);
   assign bus.done    = (state == DONE);
   assign bus.rdidx   = idx;
   assign bus.outdata = outdata;
   assign bus.outvld  = outvld;

   // State register; reset abandons any command in flight without a done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: READ ends once nothing is left to issue and the last word leaves.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt = (bus.len == '0) ? DONE : READ;
            end
         end
         READ: begin
            if ((rem == '0) && out_free) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Index/remaining counters and the output word register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx     <= '0;
         rem     <= '0;
         outdata <= '0;
         outvld  <= 1'b0;
      end else begin
         if (accept) begin
            idx <= bus.base;
            rem <= bus.len;
         end
         if (issue) begin
            outdata <= bus.rddata;
            outvld  <= 1'b1;
            rem     <= rem - WLEN'(1);
            idx     <= (idx == IDX_LAST) ? '0 : idx + WIDX'(1);
         end else if (xfer) begin
            outvld  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_powlib_dpram_rdr.sv
// Directed bench for powlib_dpram_rdr with an 8-entry RAM model holding
// mem[i] = 100 + i behind the combinational read port.
module tb_powlib_dpram_rdr;
   localparam int W    = 16;
   localparam int D    = 8;
   localparam int WIDX = $clog2(D);
   localparam int WLEN = WIDX + 1;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   logic [W-1:0] mem [D];

   powlib_dpram_rdr_if #(.W(W), .D(D), .WIDX(WIDX), .WLEN(WLEN)) bus ();

   powlib_dpram_rdr #(.W(W), .D(D), .WIDX(WIDX), .WLEN(WLEN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.rddata = mem[bus.rdidx];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cmd(input int b, input int l);
      bus.start = 1'b1;
      bus.base  = WIDX'(b);
      bus.len   = WLEN'(l);
      tick();
      bus.start = 1'b0;
   endtask

   initial begin
      logic [W-1:0] acc [$];
      int   pat [6];
      int   exp_d [6];
      int   exp_v [6];
      int   exp_dn [6];
      int   widx [5];

      total = 0;
      bad   = 0;
      for (int i = 0; i < D; i++) mem[i] = W'(100 + i);
      rst        = 1'b1;
      bus.start  = 1'b0;
      bus.base   = '0;
      bus.len    = '0;
      bus.outrdy = 1'b1;

      // reset state
      tick();
      tick();
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_vld", bus.outvld, 0);
      check("rst_idx", bus.rdidx, 0);
      check("rst_data", bus.outdata, 0);
      rst = 1'b0;
      tick();

      // basic drain base=2 len=4
      cmd(2, 4);
      check("basic_busy", bus.busy, 1);
      check("basic_idx", bus.rdidx, 2);
      check("basic_vld0", bus.outvld, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("basic_vld", bus.outvld, 1);
         check("basic_data", bus.outdata, 102 + i);
         check("basic_nodone", bus.done, 0);
      end
      tick();
      check("basic_done", bus.done, 1);
      check("basic_busy_done", bus.busy, 1);
      check("basic_vld_end", bus.outvld, 0);
      tick();
      check("basic_done_clr", bus.done, 0);
      check("basic_idle", bus.busy, 0);

      // wrap base=6 len=5
      widx = '{6, 7, 0, 1, 2};
      cmd(6, 5);
      for (int i = 0; i < 5; i++) begin
         check("wrap_idx", bus.rdidx, widx[i]);
         tick();
         check("wrap_data", bus.outdata, 100 + widx[i]);
         check("wrap_vld", bus.outvld, 1);
      end
      tick();
      check("wrap_done", bus.done, 1);
      tick();

      // full depth base=3 len=8
      cmd(3, 8);
      for (int i = 0; i < 8; i++) begin
         tick();
         check("full_data", bus.outdata, 100 + ((3 + i) % 8));
         check("full_vld", bus.outvld, 1);
      end
      tick();
      check("full_done", bus.done, 1);
      check("full_vld_end", bus.outvld, 0);
      tick();

      // backpressure base=0 len=3
      pat    = '{1, 0, 0, 1, 0, 1};
      exp_d  = '{101, 101, 101, 102, 102, 102};
      exp_v  = '{1, 1, 1, 1, 1, 0};
      exp_dn = '{0, 0, 0, 0, 0, 1};
      cmd(0, 3);
      tick();
      check("bp_first", bus.outdata, 100);
      for (int i = 0; i < 6; i++) begin
         bus.outrdy = pat[i][0];
         if (bus.outvld && bus.outrdy) acc.push_back(bus.outdata);
         tick();
         check("bp_vld", bus.outvld, exp_v[i]);
         if (exp_v[i] != 0) check("bp_data", bus.outdata, exp_d[i]);
         check("bp_done", bus.done, exp_dn[i]);
      end
      bus.outrdy = 1'b1;
      check("bp_count", acc.size(), 3);
      for (int i = 0; i < acc.size(); i++) check("bp_acc", acc[i], 100 + i);
      tick();

      // zero length
      cmd(5, 0);
      check("zero_done", bus.done, 1);
      check("zero_busy", bus.busy, 1);
      check("zero_vld", bus.outvld, 0);
      tick();
      check("zero_done_clr", bus.done, 0);
      check("zero_idle", bus.busy, 0);
      check("zero_vld2", bus.outvld, 0);

      // start while busy is ignored
      cmd(0, 4);
      bus.start = 1'b1;
      bus.base  = WIDX'(5);
      bus.len   = WLEN'(2);
      for (int i = 0; i < 4; i++) begin
         tick();
         bus.start = 1'b0;
         check("ign_data", bus.outdata, 100 + i);
      end
      tick();
      check("ign_done", bus.done, 1);
      tick();
      check("ign_idle", bus.busy, 0);
      tick();
      check("ign_no_second", bus.busy, 0);
      check("ign_no_vld", bus.outvld, 0);

      // async reset mid-command base=0 len=6
      cmd(0, 6);
      tick();
      check("rm_w0", bus.outdata, 100);
      tick();
      check("rm_w1", bus.outdata, 101);
      #2;
      rst = 1'b1;
      #1;
      check("rm_vld", bus.outvld, 0);
      check("rm_busy", bus.busy, 0);
      check("rm_idx", bus.rdidx, 0);
      check("rm_data", bus.outdata, 0);
      check("rm_done", bus.done, 0);
      tick();
      rst = 1'b0;
      tick();
      check("rm_nodone", bus.done, 0);
      check("rm_idle", bus.busy, 0);

      // new command after reset base=1 len=2
      cmd(1, 2);
      tick();
      check("post_w0", bus.outdata, 101);
      tick();
      check("post_w1", bus.outdata, 102);
      tick();
      check("post_done", bus.done, 1);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/powlib_dpram_rdr.md
# powlib_dpram_rdr

Read-side engine for `powlib_dpram`: on a start command it walks a contiguous, wrap-around range of memory indices, drives the RAM's combinational read port, and streams each word out through a registered valid/ready interface. Typical use is draining a buffer that a producer has already written through the dpram write port, for example a packet or frame handed off by index and length. One word per cycle sustained when the sink is ready. Completion is signalled with a one-cycle `done` pulse.

## Interface
- `W`, 16, data width; must match the attached dpram.
- `D`, 8, dpram depth; any value ≥ 2, not required to be a power of two.
- `WIDX`, `powlib_clogb2(D)`, index width.
- `WLEN`, `WIDX+1`, length width; must allow `len = D`.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  start command; sampled only in IDLE.
- `base`  in  WIDX  first index to read; must be < D.
- `len`  in  WLEN  number of words; valid range 0..D.
- `busy`  out  1  high while not IDLE.
- `done`  out  1  one-cycle pulse at end of a command.
- `rdidx`  out  WIDX  to dpram `rdidx`.
- `rddata`  in  W  from dpram `rddata`; combinational read.
- `outdata`  out  W  streamed word.
- `outvld`  out  1  `outdata` valid.
- `outrdy`  in  1  sink accepts the word.

## Operation
- **States:**
  - IDLE: `start=1` latches `base` into the index counter and `len` into the remaining counter `rem`. Goes to DONE if `len==0`, else to READ.
  - READ: issues reads until `rem==0` and the output register has drained. Then goes to DONE.
  - DONE: one cycle with `done=1`, then IDLE.
- **Start rules:**
  - `start` outside IDLE is ignored; there is no queueing.
  - `base`/`len` are sampled only on the accepted start cycle.
- **`rdidx`:** always equals the index counter, including in IDLE. Reset value 0.
- **Read issue:** in READ, a read is issued when `rem!=0` and the output register is free.
  - "Free" means `outvld==0`, or `outvld&&outrdy` in the same cycle.
- **On issue:**
  - `outdata <= rddata` and `outvld <= 1`.
  - `rem <= rem-1`.
  - Index advances: `idx <= (idx==D-1) ? 0 : idx+1`.
- **Handshake:**
  - A word transfers on `outvld&&outrdy`.
  - While `outvld=1 && outrdy=0`, `outdata`, `outvld`, the index counter and `rem` all hold.
  - `outvld` clears after a transfer with no new issue.
  - `outdata` may hold its stale value after clearing.
- **Wrap-around:**
  - The index wraps modulo D.
  - `base=D-1, len=3` reads D-1, 0, 1.
  - `len=D` reads every entry once.
- **Reset:** asserting `rst` at any time, including mid-command, immediately forces:
  - state IDLE;
  - `busy=0`, `done=0`, `outvld=0`, `outdata=0`, `rdidx=0`, `rem=0`.
  - The partially drained command is abandoned and `done` is not pulsed.
- **Concurrent writes:** writes to the dpram during a command are not the block's concern. The data read is whatever the RAM holds when the index is presented.

## Timing
- **Start at cycle t (IDLE):**
  - `busy=1` from t+1.
  - `rdidx=base` from t+1.
  - First word presented: `outvld=1`, `outdata=mem[base]` at t+2.
- **Throughput:** with `outrdy` held high, one word per cycle. Words appear at t+2 .. t+1+len.
- **Completion:** `done=1` in the cycle after the final transfer. `busy` stays high through the DONE cycle and drops the next cycle.
- **Zero length:** `len=0` at t gives `done=1` at t+1, `busy=1` at t+1 only, and no `outvld`.
- **Back-to-back commands:** the earliest next start is accepted in the first IDLE cycle, which is the cycle after DONE.
- **Ready-to-data:** the dependency from `outrdy` to the next `outdata` is one register. There is no combinational path from `outrdy` to `outvld`/`outdata`.

## Test plan
- **Basic drain:** preload mem[i]=i+100 (D=8), `start`, `base=2`, `len=4`, `outrdy=1`.
  - Expect outdata 102, 103, 104, 105 on consecutive cycles starting 2 cycles after start.
  - Expect `done` one cycle after 105 transfers.
- **Wrap:** `base=6`, `len=5`.
  - Expect 106, 107, 100, 101, 102.
  - Expect `rdidx` sequence 6, 7, 0, 1, 2.
  - Then `len=8` from base 3: all eight values, each exactly once.
- **Backpressure:** `base=0`, `len=3`, `outrdy` pattern 1,0,0,1,0,1.
  - Expect each of 100, 101, 102 held stable while `outrdy=0`.
  - Expect no duplicates or drops.
  - Expect `done` one cycle after the last accept.
- **Zero length / ignored start:** `len=0`.
  - Expect `done` at t+1 and no `outvld`.
  - A `start` pulsed while busy during a `len=4` run: output unchanged, no second command.
- **Reset mid-command:** assert `rst` asynchronously (not on a clock edge) after the 2nd word of `len=6`.
  - Expect `outvld`, `busy`, `rdidx`, `outdata` = 0 immediately and no `done`.
  - After release, a new `base=1`, `len=2` yields 101, 102.
